// File: rtl/unpacker_n_to_kbit.sv
// Width unpacker: takes one FACTOR*OUT_WIDTH word and replays it as FACTOR narrow beats.
// Valid/ready on both sides; a new word can be taken on the same edge the last beat leaves.
module unpacker_n_to_kbit #(
    parameter int FACTOR    = 3,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FACTOR*OUT_WIDTH-1:0]   data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          data_out,
    output logic                          out_last
);

    localparam int WW = FACTOR * OUT_WIDTH;
    localparam int CW = (FACTOR > 1) ? $clog2(FACTOR) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   hold_q, hold_d;

    logic                 beat_xfer;
    logic                 accept;
    logic [OUT_WIDTH-1:0] beat_slice [FACTOR];

    // Beat order is fixed at elaboration, so the slice mux only ever sees the held word.
    for (genvar gi = 0; gi < FACTOR; gi++) begin : g_slice
        localparam int SRC = MSB_FIRST ? (FACTOR - 1 - gi) : gi;
        assign beat_slice[gi] = hold_q[SRC*OUT_WIDTH +: OUT_WIDTH];
    end

    assign out_valid = (state_q == SHIFT);
    assign out_last  = out_valid && (cnt_q == CW'(FACTOR - 1));
    assign data_out  = beat_slice[cnt_q];
    assign beat_xfer = out_valid && out_ready;
    assign in_ready  = !clr && ((state_q == IDLE) || (beat_xfer && out_last));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            hold_d  = data_in;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (beat_xfer) begin
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_unpacker_n_to_kbit.sv
// Bench for unpacker_n_to_kbit: a beat-queue model checks instance A every cycle,
// directed literal expectations pin both instances (LSB-first 3x8 and MSB-first 2x16).
module tb_unpacker_n_to_kbit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [23:0] a_data_in;
    logic [7:0]  a_data_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_data_in;
    logic [15:0] b_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unpacker_n_to_kbit #(.FACTOR(3), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .data_out(a_data_out), .out_last(a_out_last)
    );

    unpacker_n_to_kbit #(.FACTOR(2), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .data_out(b_data_out), .out_last(b_out_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of instance A: a queue of beats still owed downstream.
    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;
    beat_t mq[$];

    function automatic logic model_ready();
        return !clr && (mq.size() == 0 || (mq.size() == 1 && a_out_ready));
    endfunction

    always @(negedge rstn) mq.delete();

    always @(posedge clk) begin
        logic m_acc;
        logic m_xfer;
        if (rstn) begin
            m_acc  = a_in_valid && model_ready();
            m_xfer = (mq.size() > 0) && a_out_ready;
            if (clr) begin
                mq.delete();
            end else begin
                if (m_xfer) void'(mq.pop_front());
                if (m_acc) begin
                    for (int i = 0; i < 3; i++)
                        mq.push_back('{d: 8'(a_data_in >> (8 * i)), last: (i == 2)});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("model in_ready", a_in_ready, model_ready());
            check("model out_valid", a_out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("model data_out", a_data_out, mq[0].d);
                check("model out_last", a_out_last, mq[0].last);
            end else begin
                check("model out_last idle", a_out_last, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_a(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic r);
        @(negedge clk);
        check({tag, " valid"}, a_out_valid, v);
        if (v) check({tag, " data"}, a_data_out, d);
        check({tag, " last"}, a_out_last, l);
        check({tag, " ready"}, a_in_ready, r);
        step();
    endtask

    task automatic lit_b(input string tag, input logic v, input logic [15:0] d,
                         input logic l, input logic r);
        @(negedge clk);
        check({tag, " valid"}, b_out_valid, v);
        if (v) check({tag, " data"}, b_data_out, d);
        check({tag, " last"}, b_out_last, l);
        check({tag, " ready"}, b_in_ready, r);
        step();
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_data_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0;
        #2;
        check("rst a out_valid", a_out_valid, 1'b0);
        check("rst a data_out", a_data_out, 8'h00);
        check("rst a out_last", a_out_last, 1'b0);
        check("rst b out_valid", b_out_valid, 1'b0);
        check("rst b data_out", b_data_out, 16'h0000);
        step(); step();
        rstn = 1'b1;
        lit_a("post-reset", 1'b0, 8'h00, 1'b0, 1'b1);
        $display("txn reset released");

        // single word, full rate
        a_in_valid = 1'b1; a_data_in = 24'hCAFE12; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        lit_a("t1 b0", 1'b1, 8'h12, 1'b0, 1'b0);
        lit_a("t1 b1", 1'b1, 8'hFE, 1'b0, 1'b0);
        lit_a("t1 b2", 1'b1, 8'hCA, 1'b1, 1'b1);
        lit_a("t1 idle", 1'b0, 8'h00, 1'b0, 1'b1);
        $display("txn word CAFE12 -> 12 FE CA");

        // back-to-back words
        a_in_valid = 1'b1; a_data_in = 24'h3A2A1A;
        step();
        a_data_in = 24'h6A5A4A;
        lit_a("t2 1A", 1'b1, 8'h1A, 1'b0, 1'b0);
        lit_a("t2 2A", 1'b1, 8'h2A, 1'b0, 1'b0);
        lit_a("t2 3A", 1'b1, 8'h3A, 1'b1, 1'b1);
        a_in_valid = 1'b0;
        lit_a("t2 4A", 1'b1, 8'h4A, 1'b0, 1'b0);
        lit_a("t2 5A", 1'b1, 8'h5A, 1'b0, 1'b0);
        lit_a("t2 6A", 1'b1, 8'h6A, 1'b1, 1'b1);
        lit_a("t2 idle", 1'b0, 8'h00, 1'b0, 1'b1);
        $display("txn back-to-back 3A2A1A 6A5A4A");

        // backpressure on beat 2A
        a_in_valid = 1'b1; a_data_in = 24'h3A2A1A;
        step();
        a_in_valid = 1'b0;
        lit_a("t3 1A", 1'b1, 8'h1A, 1'b0, 1'b0);
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) lit_a("t3 hold 2A", 1'b1, 8'h2A, 1'b0, 1'b0);
        a_out_ready = 1'b1;
        lit_a("t3 2A", 1'b1, 8'h2A, 1'b0, 1'b0);
        lit_a("t3 3A", 1'b1, 8'h3A, 1'b1, 1'b1);
        lit_a("t3 idle", 1'b0, 8'h00, 1'b0, 1'b1);
        $display("txn backpressure 4 cycles on 2A");

        // async reset mid-word
        a_in_valid = 1'b1; a_data_in = 24'h3A2A1A;
        step();
        a_in_valid = 1'b0;
        lit_a("t4 1A", 1'b1, 8'h1A, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("t4 rst out_valid", a_out_valid, 1'b0);
        check("t4 rst data_out", a_data_out, 8'h00);
        check("t4 rst out_last", a_out_last, 1'b0);
        step();
        rstn = 1'b1;
        lit_a("t4 released", 1'b0, 8'h00, 1'b0, 1'b1);
        a_in_valid = 1'b1; a_data_in = 24'hCAFE12;
        step();
        a_in_valid = 1'b0;
        lit_a("t4 b0", 1'b1, 8'h12, 1'b0, 1'b0);
        lit_a("t4 b1", 1'b1, 8'hFE, 1'b0, 1'b0);
        lit_a("t4 b2", 1'b1, 8'hCA, 1'b1, 1'b1);
        $display("txn reset mid-word then CAFE12");

        // clr with in_valid on the last beat
        a_in_valid = 1'b1; a_data_in = 24'h3A2A1A;
        step();
        a_in_valid = 1'b0;
        lit_a("t5 1A", 1'b1, 8'h1A, 1'b0, 1'b0);
        lit_a("t5 2A", 1'b1, 8'h2A, 1'b0, 1'b0);
        clr = 1'b1; a_in_valid = 1'b1; a_data_in = 24'h6A5A4A;
        lit_a("t5 3A clr", 1'b1, 8'h3A, 1'b1, 1'b0);
        clr = 1'b0; a_in_valid = 1'b0;
        lit_a("t5 idle", 1'b0, 8'h00, 1'b0, 1'b1);
        lit_a("t5 idle2", 1'b0, 8'h00, 1'b0, 1'b1);
        $display("txn clr on last beat drops new word");

        // MSB-first, 2 x 16
        b_in_valid = 1'b1; b_data_in = 32'h1A2A3A4A; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        lit_b("t6 b0", 1'b1, 16'h1A2A, 1'b0, 1'b0);
        lit_b("t6 b1", 1'b1, 16'h3A4A, 1'b1, 1'b1);
        lit_b("t6 idle", 1'b0, 16'h0000, 1'b0, 1'b1);
        $display("txn msb-first 1A2A3A4A -> 1A2A 3A4A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
